packet_decoder: RTL and testbench

PACKET_DECODER -- requirements
Module: packet_decoder

---
 rtl/packet_decoder.sv | 152 +++++++++++++++
 tb/tb_packet_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/packet_decoder.sv
// rtl/packet_decoder.sv - framed byte-stream decoder: SYNC, DEST, SOURCE, LENGTH, payload
//
// Purpose: pulls packets out of a UART byte stream and forwards the payload
// with start/end markers and the header fields latched alongside.
//
// Ports:
//   ipClk        in   clock, rising edge
//   reset        in   synchronous active-high reset
//   ipRxData     in   [7:0] received byte
//   ipRxValid    in   one-cycle strobe qualifying ipRxData (no backpressure)
//   opPktData    out  [7:0] payload byte, one cycle after its input strobe
//   opPktValid   out  qualifies opPktData
//   opPktSoP     out  first payload byte of the packet
//   opPktEoP     out  last payload byte of the packet
//   opPktDest    out  [7:0] destination byte of the current packet
//   opPktSource  out  [7:0] source byte of the current packet
//   opPktLength  out  [7:0] payload length of the current packet
//   opError      out  one-cycle pulse on zero length or inter-byte timeout
`timescale 1ns/1ps
module packet_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       ipClk,
    input  logic       reset,
    input  logic [7:0] ipRxData,
    input  logic       ipRxValid,
    output logic [7:0] opPktData,
    output logic       opPktValid,
    output logic       opPktSoP,
    output logic       opPktEoP,
    output logic [7:0] opPktDest,
    output logic [7:0] opPktSource,
    output logic [7:0] opPktLength,
    output logic       opError
);

    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reaches TIMEOUT_CYCLES on the edge where it currently holds this value.
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEST,
        S_SOURCE,
        S_LENGTH,
        S_PAYLOAD
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] gap_cnt_d;
    logic [7:0]       rem_cnt_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             sop_q;
    logic             eop_q;
    logic [7:0]       dest_q;
    logic [7:0]       source_q;
    logic [7:0]       length_q;
    logic             error_q;
    logic             timeout_hit;

    // A valid byte on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_q != S_IDLE) && !ipRxValid && (gap_cnt_q == CNT_LAST);

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if ((state_q == S_IDLE) || ipRxValid || timeout_hit) begin
            gap_cnt_d = '0;
        end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ipClk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            rem_cnt_q <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            dest_q    <= 8'h00;
            source_q  <= 8'h00;
            length_q  <= 8'h00;
            error_q   <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            error_q   <= 1'b0;
            gap_cnt_q <= gap_cnt_d;

            if (timeout_hit) begin
                error_q <= 1'b1;
                state_q <= S_IDLE;
            end else if (ipRxValid) begin
                case (state_q)
                    S_IDLE: begin
                        if (ipRxData == SYNC_BYTE) begin
                            state_q <= S_DEST;
                        end
                    end
                    S_DEST: begin
                        dest_q  <= ipRxData;
                        state_q <= S_SOURCE;
                    end
                    S_SOURCE: begin
                        source_q <= ipRxData;
                        state_q  <= S_LENGTH;
                    end
                    S_LENGTH: begin
                        length_q <= ipRxData;
                        if (ipRxData == 8'h00) begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            rem_cnt_q <= ipRxData;
                            state_q   <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        // SYNC_BYTE is ordinary data here; only the count ends the packet.
                        data_q    <= ipRxData;
                        valid_q   <= 1'b1;
                        sop_q     <= (rem_cnt_q == length_q);
                        eop_q     <= (rem_cnt_q == 8'd1);
                        rem_cnt_q <= rem_cnt_q - 8'd1;
                        if (rem_cnt_q == 8'd1) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign opPktData   = data_q;
    assign opPktValid  = valid_q;
    assign opPktSoP    = sop_q;
    assign opPktEoP    = eop_q;
    assign opPktDest   = dest_q;
    assign opPktSource = source_q;
    assign opPktLength = length_q;
    assign opError     = error_q;

endmodule

// File: tb/tb_packet_decoder.sv
// tb/tb_packet_decoder.sv - directed self-checking bench for packet_decoder
`timescale 1ns/1ps
module tb_packet_decoder;

    logic       ipClk;
    logic       reset;
    logic [7:0] ipRxData;
    logic       ipRxValid;
    logic [7:0] opPktData;
    logic       opPktValid;
    logic       opPktSoP;
    logic       opPktEoP;
    logic [7:0] opPktDest;
    logic [7:0] opPktSource;
    logic [7:0] opPktLength;
    logic       opError;

    int n_checks = 0;
    int n_fail   = 0;

    packet_decoder #(
        .SYNC_BYTE      (8'h55),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ipClk       (ipClk),
        .reset       (reset),
        .ipRxData    (ipRxData),
        .ipRxValid   (ipRxValid),
        .opPktData   (opPktData),
        .opPktValid  (opPktValid),
        .opPktSoP    (opPktSoP),
        .opPktEoP    (opPktEoP),
        .opPktDest   (opPktDest),
        .opPktSource (opPktSource),
        .opPktLength (opPktLength),
        .opError     (opError)
    );

    initial ipClk = 1'b0;
    always #5 ipClk = ~ipClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle, then check the registered outputs it produced.
    // flags = {valid, sop, eop, error}
    task automatic send(input logic [7:0] b, input logic [3:0] flags,
                        input logic [7:0] exp_data, input string tag);
        ipRxData  = b;
        ipRxValid = 1'b1;
        @(posedge ipClk);
        #1;
        ipRxValid = 1'b0;
        chk({tag, ".flags"}, {28'd0, opPktValid, opPktSoP, opPktEoP, opError}, {28'd0, flags});
        if (flags[3]) chk({tag, ".data"}, {24'd0, opPktData}, {24'd0, exp_data});
    endtask

    task automatic idle(input logic [3:0] flags, input string tag);
        ipRxValid = 1'b0;
        @(posedge ipClk);
        #1;
        chk({tag, ".flags"}, {28'd0, opPktValid, opPktSoP, opPktEoP, opError}, {28'd0, flags});
    endtask

    task automatic chk_hdr(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l,
                           input string tag);
        chk({tag, ".hdr"}, {8'd0, opPktDest, opPktSource, opPktLength}, {8'd0, d, s, l});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ipRxData  = 8'h00;
        ipRxValid = 1'b0;
        repeat (3) @(posedge ipClk);
        #1;
        chk("rst.flags", {28'd0, opPktValid, opPktSoP, opPktEoP, opError}, 32'd0);
        chk("rst.data", {24'd0, opPktData}, 32'd0);
        chk_hdr(8'h00, 8'h00, 8'h00, "rst");
        reset = 1'b0;
        idle(4'b0000, "rst.idle");

        // Basic three-byte packet
        send(8'h55, 4'b0000, 8'h00, "p1.sync");
        send(8'h01, 4'b0000, 8'h00, "p1.dest");
        send(8'h02, 4'b0000, 8'h00, "p1.src");
        send(8'h03, 4'b0000, 8'h00, "p1.len");
        chk_hdr(8'h01, 8'h02, 8'h03, "p1");
        send(8'hAA, 4'b1100, 8'hAA, "p1.b0");
        send(8'hBB, 4'b1000, 8'hBB, "p1.b1");
        send(8'hCC, 4'b1010, 8'hCC, "p1.b2");
        idle(4'b0000, "p1.after");
        chk_hdr(8'h01, 8'h02, 8'h03, "p1.hold");

        // Leading junk ignored; length-1 packet has SoP and EoP together
        send(8'h12, 4'b0000, 8'h00, "p2.junk0");
        send(8'h34, 4'b0000, 8'h00, "p2.junk1");
        send(8'h55, 4'b0000, 8'h00, "p2.sync");
        send(8'h07, 4'b0000, 8'h00, "p2.dest");
        send(8'h08, 4'b0000, 8'h00, "p2.src");
        send(8'h01, 4'b0000, 8'h00, "p2.len");
        chk_hdr(8'h07, 8'h08, 8'h01, "p2");
        send(8'h5A, 4'b1110, 8'h5A, "p2.b0");
        idle(4'b0000, "p2.after");

        // Zero length is a framing error, then decoding resumes
        send(8'h55, 4'b0000, 8'h00, "p3.sync");
        send(8'h01, 4'b0000, 8'h00, "p3.dest");
        send(8'h02, 4'b0000, 8'h00, "p3.src");
        send(8'h00, 4'b0001, 8'h00, "p3.len0");
        idle(4'b0000, "p3.after");
        send(8'h55, 4'b0000, 8'h00, "p3n.sync");
        send(8'h03, 4'b0000, 8'h00, "p3n.dest");
        send(8'h04, 4'b0000, 8'h00, "p3n.src");
        send(8'h01, 4'b0000, 8'h00, "p3n.len");
        send(8'h9C, 4'b1110, 8'h9C, "p3n.b0");

        // Inter-byte timeout: error exactly 8 cycles after AA, no EoP
        send(8'h55, 4'b0000, 8'h00, "p4.sync");
        send(8'h01, 4'b0000, 8'h00, "p4.dest");
        send(8'h02, 4'b0000, 8'h00, "p4.src");
        send(8'h04, 4'b0000, 8'h00, "p4.len");
        send(8'hAA, 4'b1100, 8'hAA, "p4.b0");
        for (int i = 1; i <= 7; i++) idle(4'b0000, $sformatf("p4.wait%0d", i));
        idle(4'b0001, "p4.timeout");
        idle(4'b0000, "p4.after");
        send(8'h55, 4'b0000, 8'h00, "p4n.sync");
        send(8'h0E, 4'b0000, 8'h00, "p4n.dest");
        send(8'h0F, 4'b0000, 8'h00, "p4n.src");
        send(8'h01, 4'b0000, 8'h00, "p4n.len");
        chk_hdr(8'h0E, 8'h0F, 8'h01, "p4n");
        send(8'h61, 4'b1110, 8'h61, "p4n.b0");

        // Byte arriving on the timeout cycle wins
        send(8'h55, 4'b0000, 8'h00, "p5.sync");
        send(8'h01, 4'b0000, 8'h00, "p5.dest");
        send(8'h02, 4'b0000, 8'h00, "p5.src");
        send(8'h01, 4'b0000, 8'h00, "p5.len");
        for (int i = 1; i <= 7; i++) idle(4'b0000, $sformatf("p5.wait%0d", i));
        send(8'h42, 4'b1110, 8'h42, "p5.race");
        idle(4'b0000, "p5.after");

        // Embedded SYNC is data; back-to-back packet after EoP
        send(8'h55, 4'b0000, 8'h00, "p6.sync");
        send(8'h01, 4'b0000, 8'h00, "p6.dest");
        send(8'h02, 4'b0000, 8'h00, "p6.src");
        send(8'h02, 4'b0000, 8'h00, "p6.len");
        send(8'h55, 4'b1100, 8'h55, "p6.b0");
        send(8'h66, 4'b1010, 8'h66, "p6.b1");
        send(8'h55, 4'b0000, 8'h00, "p7.sync");
        send(8'h21, 4'b0000, 8'h00, "p7.dest");
        send(8'h22, 4'b0000, 8'h00, "p7.src");
        send(8'h01, 4'b0000, 8'h00, "p7.len");
        chk_hdr(8'h21, 8'h22, 8'h01, "p7");
        send(8'h33, 4'b1110, 8'h33, "p7.b0");

        // Reset after DEST abandons the packet; bytes during reset are ignored
        send(8'h55, 4'b0000, 8'h00, "p8.sync");
        send(8'h09, 4'b0000, 8'h00, "p8.dest");
        reset     = 1'b1;
        ipRxData  = 8'h55;
        ipRxValid = 1'b1;
        @(posedge ipClk);
        #1;
        ipRxValid = 1'b0;
        chk("p8.rst.flags", {28'd0, opPktValid, opPktSoP, opPktEoP, opError}, 32'd0);
        chk("p8.rst.data", {24'd0, opPktData}, 32'd0);
        chk_hdr(8'h00, 8'h00, 8'h00, "p8.rst");
        reset = 1'b0;
        send(8'h01, 4'b0000, 8'h00, "p8.ign0");
        send(8'h02, 4'b0000, 8'h00, "p8.ign1");
        send(8'h01, 4'b0000, 8'h00, "p8.ign2");
        send(8'h44, 4'b0000, 8'h00, "p8.ign3");
        chk_hdr(8'h00, 8'h00, 8'h00, "p8.ign");
        send(8'h55, 4'b0000, 8'h00, "p9.sync");
        send(8'h0A, 4'b0000, 8'h00, "p9.dest");
        send(8'h0B, 4'b0000, 8'h00, "p9.src");
        send(8'h02, 4'b0000, 8'h00, "p9.len");
        chk_hdr(8'h0A, 8'h0B, 8'h02, "p9");
        send(8'hC3, 4'b1100, 8'hC3, "p9.b0");
        send(8'hD4, 4'b1010, 8'hD4, "p9.b1");
        idle(4'b0000, "p9.after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
